// File: rtl/prco_io_pkg.sv
// Shared definitions for the PRCO core I/O-space peripherals: bus width,
// default clock rate and LED port register addresses.
package prco_io_pkg;

    localparam int IO_DATA_W      = 16;
    localparam int CLK_HZ_DEFAULT = 50_000_000;

    localparam logic [1:0] LED_ADDR_VALUE = 2'd0;
    localparam logic [1:0] LED_ADDR_SET   = 2'd1;
    localparam logic [1:0] LED_ADDR_CLR   = 2'd2;
    localparam logic [1:0] LED_ADDR_CTRL  = 2'd3;

endpackage

// File: rtl/prco_prescaler.sv
// Divide-by-DIV tick generator: counts 0..DIV-1 and pulses tick_o for one
// cycle on the terminal count, wrapping to 0. Shared with the UART baud generator.
module prco_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = tick;

endmodule

// File: rtl/prco_led_port.sv
// Memory-mapped LED port: VALUE/SET/CLR/CTRL registers, prescaled blink mask,
// registered LED pins. PWM dimming is compiled in with PRCO_LED_PWM_EN.
module prco_led_port
    import prco_io_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [1:0]           i_addr,
    input  logic [IO_DATA_W-1:0] i_data,
    output logic [IO_DATA_W-1:0] o_data,
    output logic                 o_ack,
    output logic [7:0]           o_leds
);

    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

    logic [7:0]           value_q, value_d;
    logic [7:0]           mask_q, mask_d;
    logic                 phase_q, phase_d;
    logic                 ack_q, ack_d;
    logic [IO_DATA_W-1:0] data_q, data_d;
    logic [7:0]           leds_q, leds_d;
    logic                 live_q;
    logic                 tick;
    logic                 strobe;
    logic [7:0]           led_next;
    logic [IO_DATA_W-1:0] ctrl_rd;
    logic [IO_DATA_W-1:0] rd_data;
    logic                 pwm_on;

    prco_prescaler #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // live_q is low for the first edge after reset release, so a strobe that
    // coincides with the release is dropped rather than half-processed.
    assign strobe = i_en & live_q;

`ifdef PRCO_LED_PWM_EN
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pcnt_q;

    always_comb begin
        duty_d = duty_q;
        if (strobe && i_we && i_addr == LED_ADDR_CTRL) begin
            duty_d = i_data[8 +: PWM_BITS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '1;
            pcnt_q <= '0;
        end else begin
            duty_q <= duty_d;
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    assign pwm_on  = (pcnt_q < duty_q);
    assign ctrl_rd = {{(IO_DATA_W - 8 - PWM_BITS){1'b0}}, duty_q, mask_q};
`else
    assign pwm_on  = 1'b1;
    assign ctrl_rd = {8'h00, mask_q};
`endif

    always_comb begin
        value_d  = value_q;
        mask_d   = mask_q;
        phase_d  = phase_q ^ tick;
        ack_d    = strobe;
        data_d   = '0;
        rd_data  = (i_addr == LED_ADDR_CTRL) ? ctrl_rd : {8'h00, value_q};
        if (strobe) begin
            if (i_we) begin
                case (i_addr)
                    LED_ADDR_VALUE: value_d = i_data[7:0];
                    LED_ADDR_SET:   value_d = value_q | i_data[7:0];
                    LED_ADDR_CLR:   value_d = value_q & ~i_data[7:0];
                    default:        mask_d  = i_data[7:0];
                endcase
            end else begin
                data_d = rd_data;
            end
        end
        // Pins follow the registered VALUE/phase, hence the extra cycle of latency.
        led_next = value_q ^ (mask_q & {8{phase_q}});
        leds_d   = led_next & {8{pwm_on}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            mask_q  <= '0;
            phase_q <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            leds_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            mask_q  <= mask_d;
            phase_q <= phase_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            leds_q  <= leds_d;
            live_q  <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{i_data[15:8], PWM_BITS[0]};

    assign o_ack  = ack_q;
    assign o_data = data_q;
    assign o_leds = leds_q;

endmodule
